fetch: RTL and testbench

Instruction fetch stage of the core, directly upstream of decode and the register-file read it drives. Owns the program counter and issues word fetches on the instruction-memory strobe/ack port. Buffers returned instructions with their PC and hands them to decode over a valid/ready handshake. Handles redirects from execute and traps from the CSR unit by flushing buffered and in-flight instructions.

---
 rtl/core_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch.sv | 104 ++++++++++
 tb/tb_fetch.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and constants; FETCH_PREFETCH_EN selects a 2-deep fetch buffer
package core_pkg;

    localparam int XLEN = 32;

`ifdef FETCH_PREFETCH_EN
    localparam int FETCH_DEPTH = 2;
`else
    localparam int FETCH_DEPTH = 1;
`endif

    localparam int FETCH_OCC_W = $clog2(FETCH_DEPTH + 1);

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer of fetched {pc, instr} entries with flush
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  fetch_entry_t     i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output fetch_entry_t     o_head,
    output logic [OCC_W-1:0] o_occ
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Storage is rounded up to a power of two so any pointer value indexes in range.
    localparam int SLOTS = 1 << PTR_W;

    fetch_entry_t     r_mem [SLOTS];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             w_pop;

    assign w_pop = i_pop && (r_occ != '0);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_occ <= r_occ + OCC_W'(i_push) - OCC_W'(w_pop);
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage: PC, strobe/ack port, decode buffer; FETCH_PREFETCH_EN (via core_pkg) enables prefetch
module fetch
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] instr_addr,
    output logic            instr_stb,
    input  logic [XLEN-1:0] instr,
    input  logic            instr_ack,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_instr
);

    logic [XLEN-1:0]        r_pc;
    logic [XLEN-1:0]        r_addr;
    logic                   r_stb;
    logic                   r_kill;

    logic [XLEN-1:0]        w_pc_next;
    logic [XLEN-1:0]        w_flush_pc;
    logic                   w_stb_next;
    logic                   w_kill_next;
    logic                   w_ack;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_flush;
    logic                   w_hold;
    logic [FETCH_OCC_W-1:0] w_occ;
    logic [FETCH_OCC_W-1:0] w_occ_next;
    fetch_entry_t           w_push_entry;
    fetch_entry_t           w_head;

    assign w_ack        = r_stb & instr_ack;
    assign w_pop        = dec_valid & dec_ready;
    assign w_flush      = trap_en | redirect_en;
    assign w_hold       = r_stb & ~instr_ack;
    assign w_push       = w_ack & ~r_kill & ~w_flush;
    assign w_flush_pc   = word_align(trap_en ? trap_pc : redirect_pc);
    assign w_push_entry = '{pc: r_pc, instr: instr};

    always_comb begin
        w_pc_next   = r_pc;
        w_kill_next = r_kill;
        w_occ_next  = w_occ + FETCH_OCC_W'(w_push) - FETCH_OCC_W'(w_pop);
        if (w_flush) begin
            // An outstanding request cannot be withdrawn, so it is marked for discard.
            w_pc_next   = w_flush_pc;
            w_kill_next = w_hold;
            w_occ_next  = '0;
        end else if (w_ack) begin
            w_kill_next = 1'b0;
            if (!r_kill) begin
                w_pc_next = r_pc + 32'd4;
            end
        end
        w_stb_next = w_hold | w_kill_next | (w_occ_next < FETCH_OCC_W'(FETCH_DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc   <= PC_RESET;
            r_addr <= PC_RESET;
            r_stb  <= 1'b0;
            r_kill <= 1'b0;
        end else begin
            r_pc   <= w_pc_next;
            r_kill <= w_kill_next;
            r_stb  <= w_stb_next;
            if (!w_hold) begin
                r_addr <= w_pc_next;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FETCH_DEPTH),
        .OCC_W (FETCH_OCC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_head  (w_head),
        .o_occ   (w_occ)
    );

    assign instr_addr = r_addr;
    assign instr_stb  = r_stb;
    assign dec_valid  = (w_occ != '0);
    assign dec_pc     = w_head.pc;
    assign dec_instr  = w_head.instr;

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - directed self-checking bench for fetch with a variable-latency memory model
module tb_fetch;
    import core_pkg::*;

    localparam logic [31:0] PC_RST = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr_addr;
    logic        instr_stb;
    logic [31:0] instr = '0;
    logic        instr_ack = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap_en = 1'b0;
    logic [31:0] trap_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;

    fetch #(.PC_RESET(PC_RST)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_addr  (instr_addr),
        .instr_stb   (instr_stb),
        .instr       (instr),
        .instr_ack   (instr_ack),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .trap_en     (trap_en),
        .trap_pc     (trap_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_pc      (dec_pc),
        .dec_instr   (dec_instr)
    );

    always #5 clk = ~clk;

    int          pass_cnt = 0;
    int          total = 0;
    int          lat = 0;
    int          wait_cnt = 0;
    int          pops = 0;
    int          acks = 0;
    logic        acked = 1'b0;
    logic [31:0] exp_pc = PC_RST;
    logic [31:0] last_pop_pc = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // One clock: memory answers after `lat` wait cycles, decode pops are scored in order.
    task automatic tick();
        logic        prev_pend;
        logic [31:0] prev_addr;
        instr_ack = instr_stb && (wait_cnt >= lat);
        instr     = instr_ack ? mem_word(instr_addr) : 32'h0BAD_0BAD;
        if (dec_valid && dec_ready) begin
            total++;
            if (dec_pc !== exp_pc || dec_instr !== mem_word(exp_pc))
                $display("FAIL pop_order: got pc=%h instr=%h want pc=%h instr=%h",
                         dec_pc, dec_instr, exp_pc, mem_word(exp_pc));
            else
                pass_cnt++;
            last_pop_pc = dec_pc;
            exp_pc      = exp_pc + 32'd4;
            pops++;
        end
        if (trap_en)
            exp_pc = {trap_pc[31:2], 2'b00};
        else if (redirect_en)
            exp_pc = {redirect_pc[31:2], 2'b00};
        acked     = instr_ack;
        prev_pend = instr_stb && !instr_ack;
        prev_addr = instr_addr;
        if (instr_ack) acks++;
        @(posedge clk);
        #1;
        if (acked) wait_cnt = 0;
        else if (prev_pend) wait_cnt++;
        redirect_en = 1'b0;
        trap_en     = 1'b0;
        instr_ack   = 1'b0;
        if (prev_pend) begin
            total++;
            if (instr_stb !== 1'b1 || instr_addr !== prev_addr)
                $display("FAIL req_stable: got stb=%b addr=%h want stb=1 addr=%h",
                         instr_stb, instr_addr, prev_addr);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (instr_stb !== 1'b0 || dec_valid !== 1'b0)
            $display("FAIL reset_ctrl: got stb=%b valid=%b want 0 0", instr_stb, dec_valid);
        else pass_cnt++;
        total++;
        if (dec_pc !== 32'h0 || dec_instr !== 32'h0)
            $display("FAIL reset_data: got pc=%h instr=%h want 0 0", dec_pc, dec_instr);
        else pass_cnt++;
        rst = 1'b1;
        exp_pc = PC_RST;
        wait_cnt = 0;
        tick();
        total++;
        if (instr_stb !== 1'b1 || instr_addr !== PC_RST)
            $display("FAIL first_fetch: got stb=%b addr=%h want 1 %h", instr_stb, instr_addr, PC_RST);
        else pass_cnt++;
        tick();
        total++;
        if (dec_valid !== 1'b1 || dec_pc !== PC_RST || dec_instr !== mem_word(PC_RST))
            $display("FAIL fetch_latency: got v=%b pc=%h instr=%h want 1 %h %h",
                     dec_valid, dec_pc, dec_instr, PC_RST, mem_word(PC_RST));
        else pass_cnt++;
    endtask

    task automatic test_stream();
        int p0;
        int a0;
        int want;
        lat = 0;
        dec_ready = 1'b1;
        repeat (4) tick();
        p0 = pops;
        a0 = acks;
        repeat (10) tick();
        want = (FETCH_DEPTH == 2) ? 10 : 5;
        total++;
        if (pops - p0 != want)
            $display("FAIL stream_pops: got %0d want %0d", pops - p0, want);
        else pass_cnt++;
        total++;
        if (acks - a0 != want)
            $display("FAIL stream_acks: got %0d want %0d", acks - a0, want);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        dec_ready = 1'b0;
        repeat (5) tick();
        total++;
        if (instr_stb !== 1'b0 || dec_valid !== 1'b1)
            $display("FAIL stall_stb: got stb=%b valid=%b want 0 1", instr_stb, dec_valid);
        else pass_cnt++;
        total++;
        if (dec_pc !== exp_pc)
            $display("FAIL stall_head: got pc=%h want %h", dec_pc, exp_pc);
        else pass_cnt++;
        dec_ready = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_redirect_pending();
        int          n;
        logic [31:0] old_addr;
        int          p0;
        lat = 3;
        n = 0;
        while (!(instr_stb && wait_cnt == 1) && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n >= 20) $display("FAIL redir_setup: got timeout want pending request");
        else pass_cnt++;
        old_addr = instr_addr;
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        total++;
        if (instr_stb !== 1'b1 || instr_addr !== old_addr)
            $display("FAIL redir_hold: got stb=%b addr=%h want 1 %h", instr_stb, instr_addr, old_addr);
        else pass_cnt++;
        n = 0;
        acked = 1'b0;
        while (!acked && n < 10) begin
            tick();
            n++;
        end
        total++;
        if (!acked || instr_stb !== 1'b1 || instr_addr !== 32'h200 || dec_valid !== 1'b0)
            $display("FAIL redir_target: got ack=%b stb=%b addr=%h valid=%b want 1 1 00000200 0",
                     acked, instr_stb, instr_addr, dec_valid);
        else pass_cnt++;
        p0 = pops;
        n = 0;
        while (pops == p0 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (pops == p0 || last_pop_pc !== 32'h200)
            $display("FAIL redir_decode: got pops=%0d pc=%h want >0 00000200", pops - p0, last_pop_pc);
        else pass_cnt++;
    endtask

    task automatic test_trap_priority();
        int p0;
        lat = 0;
        repeat (3) tick();
        trap_en     = 1'b1;
        trap_pc     = 32'h0000_0080;
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        total++;
        if (instr_stb !== 1'b1 || instr_addr !== 32'h80)
            $display("FAIL trap_prio: got stb=%b addr=%h want 1 00000080", instr_stb, instr_addr);
        else pass_cnt++;
        p0 = pops;
        repeat (6) tick();
        total++;
        if (pops == p0) $display("FAIL trap_decode: got 0 pops want >0");
        else pass_cnt++;
    endtask

    task automatic test_misaligned();
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0203;
        tick();
        total++;
        if (instr_stb !== 1'b1 || instr_addr !== 32'h200)
            $display("FAIL redir_align: got stb=%b addr=%h want 1 00000200", instr_stb, instr_addr);
        else pass_cnt++;
        repeat (4) tick();
    endtask

    task automatic test_wrap();
        int n;
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        total++;
        if (instr_stb !== 1'b1 || instr_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_start: got stb=%b addr=%h want 1 fffffffc", instr_stb, instr_addr);
        else pass_cnt++;
        n = 0;
        while (!(instr_stb && instr_addr !== 32'hFFFF_FFFC) && n < 6) begin
            tick();
            n++;
        end
        total++;
        if (instr_stb !== 1'b1 || instr_addr !== 32'h0)
            $display("FAIL wrap_next: got stb=%b addr=%h want 1 00000000", instr_stb, instr_addr);
        else pass_cnt++;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        int n;
        int p0;
        lat = 3;
        n = 0;
        while (!(instr_stb && wait_cnt >= 1) && n < 10) begin
            tick();
            n++;
        end
        rst = 1'b0;
        #1;
        total++;
        if (instr_stb !== 1'b0 || dec_valid !== 1'b0)
            $display("FAIL rst_async: got stb=%b valid=%b want 0 0", instr_stb, dec_valid);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        lat = 0;
        wait_cnt = 0;
        exp_pc = PC_RST;
        tick();
        total++;
        if (instr_stb !== 1'b1 || instr_addr !== PC_RST)
            $display("FAIL rst_restart: got stb=%b addr=%h want 1 %h", instr_stb, instr_addr, PC_RST);
        else pass_cnt++;
        p0 = pops;
        repeat (5) tick();
        total++;
        if (pops == p0) $display("FAIL rst_decode: got 0 pops want >0");
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_pending();
        test_trap_priority();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
